// File: rtl/vga_sync_vertical.sv
// Vertical timing for the 640x480 VGA path: line counter, registered sync/blanking
// outputs and a supervisor that checks the spacing of the per-line vflag pulses.
module vga_sync_vertical #(
   parameter int unsigned H_DISP    = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned V_DISP    = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_TOTAL   = 525,
   parameter int unsigned LINE_CLKS = 1600,
   parameter int unsigned LINE_TOL  = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [9:0] cntHorizontal,
   input  logic       vflag,
   output logic [9:0] cntVertical,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_tick,
   output logic       sync_lost
);

   localparam logic [9:0]  HS_START = 10'(H_DISP + H_FP);
   localparam logic [9:0]  HS_END   = 10'(H_DISP + H_FP + H_SYNC);
   localparam logic [9:0]  H_VIS    = 10'(H_DISP);
   localparam logic [9:0]  VS_START = 10'(V_DISP + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_DISP + V_FP + V_SYNC);
   localparam logic [9:0]  V_VIS    = 10'(V_DISP);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [11:0] LINE_MIN = 12'(LINE_CLKS - 1 - LINE_TOL);
   localparam logic [11:0] LINE_MAX = 12'(LINE_CLKS - 1 + LINE_TOL);
   localparam logic [11:0] CNT_SAT  = '1;

   typedef enum logic {
      ST_UNLOCKED,
      ST_LOCKED
   } mon_state_e;

   mon_state_e  state_q, state_d;
   logic [11:0] line_cnt_q, line_cnt_d;
   logic [9:0]  cnt_vertical_q, cnt_vertical_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        video_on_q, video_on_d;
   logic        frame_tick_q, frame_tick_d;
   logic        sync_lost_q, sync_lost_d;

   always_comb begin
      cnt_vertical_d = cnt_vertical_q;
      frame_tick_d   = 1'b0;
      if (vflag) begin
         if (cnt_vertical_q == V_LAST) begin
            cnt_vertical_d = '0;
            frame_tick_d   = 1'b1;
         end else begin
            cnt_vertical_d = cnt_vertical_q + 10'd1;
         end
      end

      // vsync and video_on look at the next line value so they switch with the counter
      hsync_d    = !((cntHorizontal >= HS_START) && (cntHorizontal < HS_END));
      vsync_d    = !((cnt_vertical_d >= VS_START) && (cnt_vertical_d < VS_END));
      video_on_d = (cntHorizontal < H_VIS) && (cnt_vertical_d < V_VIS);

      state_d     = state_q;
      line_cnt_d  = line_cnt_q;
      sync_lost_d = sync_lost_q;
      case (state_q)
         ST_UNLOCKED: begin
            if (vflag) begin
               line_cnt_d = '0;
               state_d    = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (vflag) begin
               line_cnt_d = '0;
               if ((line_cnt_q < LINE_MIN) || (line_cnt_q > LINE_MAX)) begin
                  sync_lost_d = 1'b1;
               end
            end else if (line_cnt_q >= LINE_MAX) begin
               // the count would step past the tolerance window on this edge
               sync_lost_d = 1'b1;
               state_d     = ST_UNLOCKED;
            end else if (line_cnt_q != CNT_SAT) begin
               line_cnt_d = line_cnt_q + 12'd1;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q        <= ST_UNLOCKED;
         line_cnt_q     <= '0;
         cnt_vertical_q <= '0;
         hsync_q        <= 1'b1;
         vsync_q        <= 1'b1;
         video_on_q     <= 1'b0;
         frame_tick_q   <= 1'b0;
         sync_lost_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         line_cnt_q     <= line_cnt_d;
         cnt_vertical_q <= cnt_vertical_d;
         hsync_q        <= hsync_d;
         vsync_q        <= vsync_d;
         video_on_q     <= video_on_d;
         frame_tick_q   <= frame_tick_d;
         sync_lost_q    <= sync_lost_d;
      end
   end

   assign cntVertical = cnt_vertical_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_tick  = frame_tick_q;
   assign sync_lost   = sync_lost_q;

endmodule
